// File: rtl/rr_sel_arbiter.sv
// Round-robin arbiter for a downstream 4-to-1 mux: grants one channel at a time,
// releases on done, requester withdrawal or hold limit, with registered outputs.
module rr_sel_arbiter #(
  parameter int HOLD_MAX = 15,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       done,
  output logic [1:0] sel,
  output logic [3:0] gnt,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(HOLD_MAX - 1);
  localparam logic [CNT_W-1:0] CNT_SAT   = '1;

  state_t           state;
  logic [1:0]       ptr;
  logic [CNT_W-1:0] cnt;

  logic [1:0] pick_idx;
  logic       pick_valid;
  logic       hit_limit;
  logic       release_now;

  // Walk the search order backwards so the earliest candidate from ptr wins.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    pick_idx   = ptr;
    pick_valid = 1'b0;
    for (int off = 3; off >= 0; off--) begin
      if (req[ptr + 2'(off)]) begin
        pick_idx   = ptr + 2'(off);
        pick_valid = 1'b1;
      end
    end
  end

  assign hit_limit   = (cnt == CNT_LIMIT);
  assign release_now = done || !req[sel] || hit_limit;

  // NOTE: state registers use non-blocking assignments so every update sees
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      sel     <= 2'b00;
      gnt     <= 4'b0000;
      busy    <= 1'b0;
      timeout <= 1'b0;
      ptr     <= 2'b00;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          timeout <= 1'b0;
          if (pick_valid) begin
            sel   <= pick_idx;
            gnt   <= 4'b0001 << pick_idx;
            busy  <= 1'b1;
            cnt   <= '0;
            state <= GRANT;
          end
        end
        GRANT: begin
          if (release_now) begin
            gnt     <= 4'b0000;
            busy    <= 1'b0;
            ptr     <= sel + 2'd1;
            cnt     <= '0;
            state   <= IDLE;
            // Only a pure hold-limit release pulses; done or withdrawal win.
            timeout <= !done && req[sel] && hit_limit;
          end else begin
            timeout <= 1'b0;
            if (cnt != CNT_SAT) cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/rr_sel_arbiter.md
RR_SEL_ARBITER -- requirements
Module: rr_sel_arbiter

Interface
REQ-001 The parameter HOLD_MAX SHALL default to 15 and give the maximum grant length in cycles (legal range 1..255).
REQ-002 The parameter CNT_W SHALL default to 8 and set the hold-counter width.
REQ-003 The port clk SHALL be an input, 1 bit wide, and be the single clock; all state updates on its rising edge.
REQ-004 The port rst_n SHALL be an input, 1 bit wide, and act as the synchronous, active-low reset.
REQ-005 The port req SHALL be an input, 4 bits wide, with req[i] requesting routing of channel i through the 4-to-1 mux.
REQ-006 The port done SHALL be an input, 1 bit wide, asserted by the current grantee to end its grant.
REQ-007 The port sel SHALL be an output, 2 bits wide, driving the downstream 4-to-1 mux select s[1:0].
REQ-008 The port gnt SHALL be an output, 4 bits wide, one-hot grant with gnt[i] set while channel i owns the mux.
REQ-009 The port busy SHALL be an output, 1 bit wide, high while any grant is active.
REQ-010 The port timeout SHALL be an output, 1 bit wide, giving a 1-cycle pulse when a grant is revoked by the hold limit.

Function
REQ-011 The block SHALL implement a two-state FSM: IDLE and GRANT.
REQ-012 All outputs SHALL be registered; no combinational path SHALL exist from any input to any output.
REQ-013 The block SHALL keep a 2-bit priority pointer ptr; the search order is ptr, ptr+1, ptr+2, ptr+3 (mod 4).
REQ-014 In IDLE with req != 0 at an edge, the block SHALL select the first set req bit in search order, set sel to that index and gnt to the matching one-hot value, set busy=1, clear the counter to 0, and enter GRANT; grant latency is 1 cycle.
REQ-015 In IDLE with req == 0, the FSM SHALL stay in IDLE and sel SHALL hold its last value, so the mux output stays stable.
REQ-016 In GRANT, the counter SHALL increment by 1 per cycle and SHALL saturate rather than wrap.
REQ-017 The grant SHALL be released at the edge where either of these holds: done=1, or req[sel]=0 (requester withdrew).
REQ-018 The grant SHALL also be released at the edge where the counter equals HOLD_MAX-1 (timeout), so a grant lasts at most HOLD_MAX cycles.
REQ-019 On release: gnt=0, busy=0, ptr=sel+1 (mod 4, wrapping 3->0), FSM to IDLE, and sel unchanged.
REQ-020 After every release, the FSM SHALL spend at least 1 IDLE cycle before the next grant, because a release cannot also grant.
REQ-021 timeout SHALL be 1 for exactly the one cycle after a release caused by the hold limit, and 0 otherwise.
REQ-022 If done and the timeout condition coincide, done SHALL take priority and timeout SHALL stay 0.
REQ-023 done SHALL be ignored in IDLE.
REQ-024 Changes to req bits other than req[sel] SHALL not affect an active grant.
REQ-025 gnt SHALL always be zero or one-hot, and busy SHALL equal the OR of the gnt bits.

Reset
REQ-026 While rst_n=0 at an edge, the block SHALL set: state=IDLE, sel=2'b00, gnt=4'b0000, busy=0, timeout=0, ptr=0, counter=0.
REQ-027 Reset SHALL override all other inputs, including mid-grant; the grant is dropped at that edge with no timeout pulse.
REQ-028 After rst_n returns to 1, arbitration SHALL restart with channel 0 highest priority.

Verification
REQ-029 The bench SHALL cover: after reset, req=4'b1010 held -> gnt=4'b0010, sel=1 one cycle later; done pulse -> gnt=0; 1 IDLE cycle later -> gnt=4'b1000, sel=3.
REQ-030 The bench SHALL cover: req=4'b1111 held, with done pulsed after each grant -> grant order 0,1,2,3,0, with the pointer wrapping from 3 to 0.
REQ-031 The bench SHALL cover: HOLD_MAX=4, req=4'b0100 held, done=0 -> gnt=4'b0100 for exactly 4 cycles, then gnt=0 and timeout=1 for 1 cycle, then channel 2 is regranted after the IDLE cycle.
REQ-032 The bench SHALL cover: HOLD_MAX=4 with done=1 on the 4th grant cycle -> release with timeout=0.
REQ-033 The bench SHALL cover: the grantee drops req mid-grant -> release at the next edge, with ptr advanced past that channel.
REQ-034 The bench SHALL cover: rst_n=0 for 1 cycle during a grant on channel 3 -> next cycle gnt=0, sel=0, busy=0, timeout=0; req=4'b1001 afterwards -> channel 0 granted.
